// File: rtl/pipo_load_arbiter_pkg.sv
// Shared types and default sizing for the PIPO load arbiter.
// Contents: arbiter FSM state type, default requester count and word width.
package pipo_load_arbiter_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 4;

  // Arbitration sequence: IDLE picks a winner, LOAD captures, GAP lets req settle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// Requester-side bus of the PIPO load arbiter.
// Signals: req (per-requester load request), data (packed words, requester i
// at [i*WIDTH +: WIDTH]), gnt (one-hot grant), busy, q (shared register),
// owner (index of requester whose word is in q), load_cnt (completed loads).
// Modports: master = requesters / observer side, slave = arbiter side.
interface pipo_load_arbiter_if #(
  parameter int unsigned N_REQ = pipo_load_arbiter_pkg::N_REQ_DEF,
  parameter int unsigned WIDTH = pipo_load_arbiter_pkg::WIDTH_DEF
) ();

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [OW-1:0]          owner;
  logic [7:0]             load_cnt;

  modport master (
    output req, data,
    input  gnt, busy, q, owner, load_cnt
  );

  modport slave (
    input  req, data,
    output gnt, busy, q, owner, load_cnt
  );

endinterface

// File: rtl/pipo_reg.sv
// WIDTH-bit parallel-in parallel-out register with load enable.
// Ports: clk, rst_n (async active-low, clears q), load (capture strobe),
// d (parallel input), q (parallel output, holds while load is low).
module pipo_reg #(
  parameter int unsigned WIDTH = pipo_load_arbiter_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to one shared
// WIDTH-bit PIPO register. Each grant is IDLE -> LOAD -> GAP (3 cycles).
// Ports: clk, rst_n (async active-low), bus (slave side of
// pipo_load_arbiter_if: req/data in, gnt/busy/q/owner/load_cnt out).
module pipo_load_arbiter
  import pipo_load_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  pipo_load_arbiter_if.slave bus
);

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state, state_nxt;
  logic [OW-1:0]    ptr;
  logic [OW-1:0]    winner;
  logic [OW-1:0]    win_sel;
  logic             found;
  logic             load_c;
  logic [N_REQ-1:0] gnt_nxt;
  logic [N_REQ-1:0] gnt_r;
  logic             busy_r;
  logic [OW-1:0]    owner_r;
  logic [7:0]       load_cnt_r;
  logic [WIDTH-1:0] d_sel;
  logic [WIDTH-1:0] q_w;

  // Round-robin search: first active request starting just after ptr.
  always_comb begin
    int unsigned idx;
    win_sel = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_sel = OW'(idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, load strobe and next grant.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    gnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt        = LOAD;
          gnt_nxt[win_sel] = 1'b1;
        end
      end
      LOAD: begin
        load_c    = 1'b1;
        state_nxt = GAP;
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Winner latch, rotation pointer, owner, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner     <= '0;
      ptr        <= OW'(N_REQ - 1);
      owner_r    <= '0;
      load_cnt_r <= '0;
      gnt_r      <= '0;
      busy_r     <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        winner <= win_sel;
      end
      if (load_c) begin
        ptr        <= winner;
        owner_r    <= winner;
        load_cnt_r <= load_cnt_r + 8'd1;
      end
      gnt_r  <= gnt_nxt;
      busy_r <= (state_nxt != IDLE);
    end
  end

  // Data of the latched winner; only captured while load_c is high.
  assign d_sel = bus.data[32'(winner)*WIDTH +: WIDTH];

  pipo_reg #(.WIDTH(WIDTH)) u_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load_c),
    .d    (d_sel),
    .q    (q_w)
  );

  assign bus.gnt      = gnt_r;
  assign bus.busy     = busy_r;
  assign bus.q        = q_w;
  assign bus.owner    = owner_r;
  assign bus.load_cnt = load_cnt_r;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter (N_REQ=4, WIDTH=4).
module tb_pipo_load_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] q;
    logic [1:0] owner;
    logic [7:0] cnt;
    int         dly;
    bit         abort;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  pipo_load_arbiter_if #(.N_REQ(4), .WIDTH(4)) bus ();

  pipo_load_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void push(logic [3:0] g, logic [3:0] qv, logic [1:0] o,
                               logic [7:0] c, int d, bit ab);
    exp_t e;
    e.gnt = g; e.q = qv; e.owner = o; e.cnt = c; e.dly = d; e.abort = ab;
    sb.push_back(e);
  endfunction

  // Monitor: pops on every grant, checks q/owner/load_cnt one cycle later.
  initial begin
    exp_t pend;
    exp_t e;
    bit   pend_v;
    int   cyc;
    int   last_cyc;
    pend_v = 0; cyc = 0; last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_v) begin
        check("mon_q", 32'(bus.q), 32'(pend.q));
        check("mon_owner", 32'(bus.owner), 32'(pend.owner));
        check("mon_load_cnt", 32'(bus.load_cnt), 32'(pend.cnt));
        pend_v = 0;
      end
      if (bus.gnt != 4'b0) begin
        if (sb.size() == 0) begin
          check("mon_unexpected_gnt", 32'(bus.gnt), 32'(0));
        end else begin
          e = sb.pop_front();
          check("mon_gnt", 32'(bus.gnt), 32'(e.gnt));
          if (e.dly != 0) check("mon_spacing", 32'(cyc - last_cyc), 32'(e.dly));
          last_cyc = cyc;
          if (!e.abort) begin
            pend   = e;
            pend_v = 1;
          end
        end
      end
    end
  end

  // One cycle; a requester drops req once it sees its grant.
  task automatic tick();
    @(negedge clk);
    bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic set_d(int i, logic [3:0] v);
    bus.data[i*4 +: 4] = v;
  endtask

  task automatic wait_idle(string nm, int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.req == 4'b0 && !bus.busy && sb.size() == 0) && n < budget);
    if (!(bus.req == 4'b0 && !bus.busy && sb.size() == 0))
      check({nm, "_drain_timeout"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.data = '0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(bus.q), 32'(0));
    check("rst_owner", 32'(bus.owner), 32'(0));
    check("rst_load_cnt", 32'(bus.load_cnt), 32'(0));
    check("rst_gnt", 32'(bus.gnt), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester: grant next cycle, q after two edges; data moved in GAP.
    set_d(0, 4'hA);
    bus.req = 4'b0001;
    push(4'b0001, 4'hA, 2'd0, 8'd1, 0, 0);
    tick();
    check("t1_gnt_latency", 32'(bus.gnt), 32'(4'b0001));
    check("t1_busy_load", 32'(bus.busy), 32'(1));
    tick();
    set_d(0, 4'h7);
    wait_idle("t1", 20);
    check("t1_q_hold_after_gap", 32'(bus.q), 32'(4'hA));

    // All four requesting after reset: order 0,1,2,3 every 3 cycles.
    do_reset();
    set_d(0, 4'h3); set_d(1, 4'hC); set_d(2, 4'h6); set_d(3, 4'h9);
    bus.req = 4'b1111;
    push(4'b0001, 4'h3, 2'd0, 8'd1, 0, 0);
    push(4'b0010, 4'hC, 2'd1, 8'd2, 3, 0);
    push(4'b0100, 4'h6, 2'd2, 8'd3, 3, 0);
    push(4'b1000, 4'h9, 2'd3, 8'd4, 3, 0);
    wait_idle("t2", 40);

    // Rotation: after requester 1 wins, 0101 grants 2 before 0.
    do_reset();
    set_d(0, 4'h1); set_d(1, 4'h2); set_d(2, 4'h7);
    bus.req = 4'b0011;
    push(4'b0001, 4'h1, 2'd0, 8'd1, 0, 0);
    push(4'b0010, 4'h2, 2'd1, 8'd2, 3, 0);
    wait_idle("t3a", 30);
    bus.req = 4'b0101;
    push(4'b0100, 4'h7, 2'd2, 8'd3, 0, 0);
    push(4'b0001, 4'h1, 2'd0, 8'd4, 3, 0);
    wait_idle("t3b", 30);

    // Reset pulse during LOAD aborts the load.
    do_reset();
    set_d(1, 4'h5);
    bus.req = 4'b0010;
    push(4'b0010, 4'h0, 2'd0, 8'd0, 0, 1);
    tick();
    #1;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    check("t4_q", 32'(bus.q), 32'(0));
    check("t4_load_cnt", 32'(bus.load_cnt), 32'(0));
    check("t4_gnt", 32'(bus.gnt), 32'(0));
    check("t4_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_q_after", 32'(bus.q), 32'(0));
    check("t4_cnt_after", 32'(bus.load_cnt), 32'(0));
    bus.req = 4'b0010;
    push(4'b0010, 4'h5, 2'd1, 8'd1, 0, 0);
    wait_idle("t4", 20);

    // 256 back-to-back loads from requester 0: counter wraps to 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while ((bus.req != 4'b0 || bus.busy) && n < 20) begin
        tick();
        n++;
      end
      set_d(0, 4'(i));
      bus.req = 4'b0001;
      push(4'b0001, 4'(i), 2'd0, 8'(i + 1), (i == 0) ? 0 : 3, 0);
      tick();
    end
    wait_idle("t5", 20);
    check("t5_load_cnt_wrap", 32'(bus.load_cnt), 32'(0));
    check("t5_final_q", 32'(bus.q), 32'(4'hF));

    // Data churn while idle with no requests leaves q alone.
    for (int k = 0; k < 4; k++) begin
      bus.data = 16'h1234 * 16'(k + 1);
      tick();
      check("t6_q_hold", 32'(bus.q), 32'(4'hF));
      check("t6_busy", 32'(bus.busy), 32'(0));
      check("t6_gnt", 32'(bus.gnt), 32'(0));
    end

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
